// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    // Words the controller can hold locally (skid buffer entries).
    localparam int SKID_DEPTH   = 2;
    // Cycles from fifo_rd_en sampled high to fifo_dout valid.
    localparam int READ_LATENCY = 1;

endpackage

// File: rtl/fifo_rd_drain_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the drain controller.
// master: the drain controller; slave: FIFO + consumer side.
interface fifo_rd_drain_ctrl_if #(
    parameter int DW = 4
);
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry, order-preserving holding buffer for words fetched from the FIFO.
// Caller guarantees no push when full and no pop when empty.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    occ
);
    logic [DW-1:0] mem [SKID_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;

    // Pointer/occupancy bookkeeping and entry writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_drain_ctrl.sv
// Read-side drain engine: pulls words out of the FIFO while enabled, keeps at most
// SKID_DEPTH words outstanding, and streams them downstream framed into bursts.
// Optional: define RD_CHECKSUM_EN to add a per-burst XOR checksum (chk_data/chk_valid).
module fifo_rd_drain_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DW        = 4,
    parameter int BURST_LEN = 8,
    parameter int CW        = 4
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 enable,
    fifo_rd_drain_ctrl_if.master bus,
`ifdef RD_CHECKSUM_EN
    output logic [DW-1:0]        chk_data,
    output logic                 chk_valid,
`endif
    output logic                 busy
);
    rd_state_t     state;
    logic          inflight;
    logic [1:0]    occ;
    logic [DW-1:0] head;
    logic [CW-1:0] bcnt;
    logic          occ_nz;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [2:0]    outstanding;

    assign occ_nz      = (occ != 2'd0);
    assign outstanding = 3'(occ) + 3'(inflight);

    // Never request more words than there are free slots to land them in.
    assign bus.fifo_rd_en = (state == FETCH) && !bus.fifo_empty &&
                            (outstanding < 3'(SKID_DEPTH));

    // The arriving word is presented straight from fifo_dout when the buffer is empty,
    // so a word is visible the cycle after its read; it is parked only if not taken.
    assign bus.m_valid = occ_nz || inflight;
    assign bus.m_data  = occ_nz ? head : (inflight ? bus.fifo_dout : '0);
    assign bus.m_last  = (bcnt == CW'(BURST_LEN - 1));

    assign xfer = bus.m_valid && bus.m_ready;
    assign pop  = occ_nz && bus.m_ready;
    assign push = inflight && !(!occ_nz && bus.m_ready);

    rd_skid_buf #(.DW(DW)) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Track the read whose data lands on fifo_dout next cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) inflight <= 1'b0;
        else        inflight <= bus.fifo_rd_en;
    end

    // Burst position; survives enable gaps, only reset clears it.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)      bcnt <= '0;
        else if (xfer)   bcnt <= bus.m_last ? '0 : bcnt + CW'(1);
    end

    // Control FSM with registered busy.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= FETCH;
                    busy  <= 1'b1;
                end
                FETCH: if (!enable) state <= FLUSH;
                FLUSH: begin
                    if (enable) begin
                        state <= FETCH;
                    end else if (!occ_nz && !inflight) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RD_CHECKSUM_EN
    logic [DW-1:0] chk_acc;

    // XOR the words of each burst; publish and clear after the last one is taken.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            chk_acc   <= '0;
            chk_data  <= '0;
            chk_valid <= 1'b0;
        end else begin
            chk_valid <= 1'b0;
            if (xfer) begin
                if (bus.m_last) begin
                    chk_data  <= chk_acc ^ bus.m_data;
                    chk_valid <= 1'b1;
                    chk_acc   <= '0;
                end else begin
                    chk_acc   <= chk_acc ^ bus.m_data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// Self-checking bench for fifo_rd_drain_ctrl with a 1-cycle-latency FIFO model and
// a scoreboard of expected stream words (data + last flag).
module tb_fifo_rd_drain_ctrl;
    localparam int DW = 4;
    localparam int BL = 4;

    logic rd_clk = 1'b0;
    logic rd_rst;
    logic enable;
    logic busy;
`ifdef RD_CHECKSUM_EN
    logic [DW-1:0] chk_data;
    logic          chk_valid;
`endif

    fifo_rd_drain_ctrl_if #(.DW(DW)) bus();

    fifo_rd_drain_ctrl #(.DW(DW), .BURST_LEN(BL), .CW(4)) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .enable    (enable),
        .bus       (bus.master),
`ifdef RD_CHECKSUM_EN
        .chk_data  (chk_data),
        .chk_valid (chk_valid),
`endif
        .busy      (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    int            bcnt = 0;
    int            rd_cnt = 0;
    int            cyc = 0;
    int            xfer_cyc_q[$];
    int            rd_cyc_q[$];
    bit            force_nonempty = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] chk_acc = '0;
    logic [DW-1:0] chk_exp = '0;
    bit            chk_pend = 1'b0;

    // Load a word into the FIFO model and record what the stream must deliver for it.
    task automatic push_word(input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.last = (bcnt == BL - 1);
        fifo_q.push_back(d);
        exp_q.push_back(e);
        bcnt = (bcnt + 1) % BL;
    endtask

    // FIFO model: data appears on fifo_dout one cycle after a sampled read.
    always @(posedge rd_clk) begin
        if (bus.fifo_rd_en) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_overread: rd_en=1 with model FIFO empty, required no read");
            end else begin
                bus.fifo_dout <= fifo_q.pop_front();
            end
        end
    end

    // Empty flag follows the model contents, updated away from the clock edge.
    always @(posedge rd_clk) begin
        #2;
        bus.fifo_empty = force_nonempty ? 1'b0 : (fifo_q.size() == 0);
    end

    // Stream monitor / scoreboard.
    always @(negedge rd_clk) begin
        exp_t e;
        cyc++;
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            rd_cyc_q.push_back(cyc);
        end
        if (!rd_rst) begin
            if (prev_stall) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%0d, required valid=1 data=%0d",
                             bus.m_valid, bus.m_data, prev_data);
                end
            end
`ifdef RD_CHECKSUM_EN
            n_checks++;
            if (chk_pend) begin
                if (chk_valid !== 1'b1 || chk_data !== chk_exp) begin
                    n_fail++;
                    $display("FAIL checksum: chk_valid=%b chk_data=%h, required 1 / %h",
                             chk_valid, chk_data, chk_exp);
                end
                chk_pend = 1'b0;
            end else if (chk_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL chk_valid_idle: chk_valid=%b, required 0", chk_valid);
            end
`endif
            if (bus.m_valid && bus.m_ready) begin
                xfer_cyc_q.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_word: got data=%0d, required no transfer", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e.data || bus.m_last !== e.last) begin
                        n_fail++;
                        $display("FAIL stream_word: data=%0d last=%b, required data=%0d last=%b",
                                 bus.m_data, bus.m_last, e.data, e.last);
                    end
                    if (e.last) begin
                        chk_exp  = chk_acc ^ e.data;
                        chk_acc  = '0;
                        chk_pend = 1'b1;
                    end else begin
                        chk_acc = chk_acc ^ e.data;
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge rd_clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        enable = 1'b1;
        bus.m_ready = 1'b0;
        force_nonempty = 1'b1;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        n_checks += 5;
        if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (bus.m_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (bus.m_data !== 4'd0)     begin n_fail++; $display("FAIL reset_m_data: got %0d, required 0", bus.m_data); end
        if (bus.m_last !== 1'b0)     begin n_fail++; $display("FAIL reset_m_last: got %b, required 0", bus.m_last); end
        enable = 1'b0;
        force_nonempty = 1'b0;
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        repeat (2) @(posedge rd_clk);
    endtask

    task automatic test_stream();
        bit ok;
        @(posedge rd_clk); #1;
        xfer_cyc_q.delete();
        bus.m_ready = 1'b1;
        push_word(4'd11); push_word(4'd6); push_word(4'd5); push_word(4'd9);
        enable = 1'b1;
        wait_drained(40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stream_drain: %0d words left, required 0", exp_q.size()); end
        n_checks++;
        if (xfer_cyc_q.size() != 4 || xfer_cyc_q[3] - xfer_cyc_q[0] != 3) begin
            n_fail++;
            $display("FAIL stream_back_to_back: %0d transfers, required 4 in consecutive cycles", xfer_cyc_q.size());
        end
        repeat (2) @(negedge rd_clk);
        @(posedge rd_clk); #1;
        enable = 1'b0;
        wait_idle(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stream_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int r0;
        @(posedge rd_clk); #1;
        xfer_cyc_q.delete();
        bus.m_ready = 1'b0;
        r0 = rd_cnt;
        push_word(4'd11); push_word(4'd6); push_word(4'd5); push_word(4'd9); push_word(4'd8);
        enable = 1'b1;
        repeat (6) @(negedge rd_clk);
        n_checks += 3;
        if (rd_cnt - r0 != 2)     begin n_fail++; $display("FAIL bp_reads: got %0d reads, required 2", rd_cnt - r0); end
        if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", bus.m_valid); end
        if (bus.m_data !== 4'd11) begin n_fail++; $display("FAIL bp_data: got %0d, required 11", bus.m_data); end
        @(posedge rd_clk); #1;
        bus.m_ready = 1'b1;
        wait_drained(40, ok);
        n_checks++;
        if (!ok || xfer_cyc_q.size() != 5) begin
            n_fail++;
            $display("FAIL bp_release: %0d transfers, %0d left, required 5 and 0", xfer_cyc_q.size(), exp_q.size());
        end
        @(posedge rd_clk); #1;
        enable = 1'b0;
        wait_idle(20, ok);
    endtask

    task automatic test_flush();
        bit ok;
        int r0;
        int r1;
        @(posedge rd_clk); #1;
        bus.m_ready = 1'b0;
        r0 = rd_cnt;
        push_word(4'd1); push_word(4'd2); push_word(4'd3);
        enable = 1'b1;
        repeat (5) @(negedge rd_clk);
        n_checks++;
        if (rd_cnt - r0 != 2) begin n_fail++; $display("FAIL flush_pre_reads: got %0d, required 2", rd_cnt - r0); end
        @(posedge rd_clk); #1;
        enable = 1'b0;
        r1 = rd_cnt;
        repeat (2) @(negedge rd_clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy: got %b, required 1", busy); end
        @(posedge rd_clk); #1;
        bus.m_ready = 1'b1;
        wait_idle(30, ok);
        n_checks += 3;
        if (!ok)                 begin n_fail++; $display("FAIL flush_idle: busy=%b, required 0", busy); end
        if (rd_cnt != r1)        begin n_fail++; $display("FAIL flush_no_read: got %0d reads, required 0", rd_cnt - r1); end
        if (exp_q.size() != 1)   begin n_fail++; $display("FAIL flush_delivered: %0d pending, required 1", exp_q.size()); end
        // Drain the word left in the FIFO so later scenarios start clean.
        @(posedge rd_clk); #1;
        enable = 1'b1;
        wait_drained(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL flush_cleanup: %0d left, required 0", exp_q.size()); end
        @(posedge rd_clk); #1;
        enable = 1'b0;
        wait_idle(20, ok);
    endtask

    task automatic test_empty_edge();
        bit ok;
        int r0;
        @(posedge rd_clk); #1;
        xfer_cyc_q.delete();
        rd_cyc_q.delete();
        bus.m_ready = 1'b1;
        enable = 1'b1;
        r0 = rd_cnt;
        push_word(4'd7);
        wait_drained(20, ok);
        repeat (5) @(negedge rd_clk);
        n_checks += 4;
        if (!ok)                       begin n_fail++; $display("FAIL empty_delivered: %0d left, required 0", exp_q.size()); end
        if (rd_cnt - r0 != 1)          begin n_fail++; $display("FAIL empty_reads: got %0d, required 1", rd_cnt - r0); end
        if (bus.fifo_rd_en !== 1'b0)   begin n_fail++; $display("FAIL empty_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (xfer_cyc_q.size() != 1 || rd_cyc_q.size() != 1 || xfer_cyc_q[0] - rd_cyc_q[0] != 1) begin
            n_fail++;
            $display("FAIL empty_latency: %0d reads %0d transfers, required 1 each one cycle apart",
                     rd_cyc_q.size(), xfer_cyc_q.size());
        end
        @(posedge rd_clk); #1;
        enable = 1'b0;
        wait_idle(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL empty_idle: busy=%b, required 0", busy); end
    endtask

    initial begin
        rd_rst = 1'b1;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_empty_edge();
        repeat (3) @(negedge rd_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
